// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable word length, parity and stop bits,
// with parity/framing/overrun detection and a show-ahead receive FIFO.
module uart_rx_param #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               rx,
   output logic [DATA_BITS-1:0]               data_out,
   output logic                               data_valid,
   input  logic                               data_ready,
   output logic                               parity_err,
   output logic                               frame_err,
   output logic                               overrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

   localparam int CPB    = CLK_FREQ / BAUD;
   localparam int CNT_W  = $clog2(CPB + 1);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0]  BIT_TICKS  = CNT_W'(CPB);
   localparam logic [CNT_W-1:0]  HALF_TICKS = CNT_W'(CPB / 2);
   localparam logic [BIT_W-1:0]  LAST_DATA  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  LAST_STOP  = BIT_W'(STOP_BITS - 1);
   localparam logic [FCNT_W-1:0] FULL_COUNT = FCNT_W'(FIFO_DEPTH);
   localparam logic              ODD_PAR    = (PARITY == 2);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_BREAK = 3'd6;

   logic [1:0]           sync_q, sync_d;
   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]    count_q, count_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

   logic rx_s, tick, push, pop, full;

   assign rx_s = sync_q[1];
   // A sample is taken on the edge where the down-counter reads 1.
   assign tick = (cnt_q == CNT_W'(1));
   assign full = (count_q == FULL_COUNT);
   assign pop  = data_valid & data_ready;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      sync_d       = {sync_q[0], rx};
      state_d      = state_q;
      cnt_d        = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      bit_d        = bit_q;
      shreg_d      = shreg_q;
      perr_d       = perr_q;
      ferr_d       = ferr_q;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
      push         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               cnt_d   = HALF_TICKS;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  cnt_d   = BIT_TICKS;
                  bit_d   = '0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
               cnt_d   = BIT_TICKS;
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         S_PAR: begin
            if (tick) begin
               perr_d  = ((^shreg_q) ^ rx_s) != ODD_PAR;
               cnt_d   = BIT_TICKS;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (!rx_s) ferr_d = 1'b1;
               cnt_d = BIT_TICKS;
               if (bit_q == LAST_STOP) state_d = S_DONE;
               else                    bit_d   = bit_q + BIT_W'(1);
            end
         end
         S_DONE: begin
            // Framing beats parity; a full FIFO is only an overrun if nothing leaves this cycle.
            if (ferr_q) begin
               frame_err_d = 1'b1;
               state_d     = S_BREAK;
            end else if (perr_q) begin
               parity_err_d = 1'b1;
               state_d      = S_IDLE;
            end else if (full && !pop) begin
               overrun_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               push    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + FCNT_W'(1);
      else if (pop && !push) count_d = count_q - FCNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q       <= 2'b11;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // NOTE: FIFO storage is not reset; data_out is gated by data_valid so it still reads 0 out of reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= shreg_q;
   end

   assign data_valid = (count_q != '0);
   assign data_out   = data_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_count = count_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboarded bench for uart_rx_param: three receivers (8N1, 8E1, 7O2) driven
// from a bit-level serial model, with a negedge monitor comparing popped words.
`timescale 1ns/1ps
module tb_uart_rx_param;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int DEPTH    = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_ab, rst_c;
   logic       rx_a, rx_b, rx_c;
   logic       ready_a, ready_b, ready_c;
   logic [7:0] dout_a, dout_b;
   logic [6:0] dout_c;
   logic [2:0] cnt_a, cnt_b, cnt_c;
   wire  [2:0] valid, perr_w, ferr_w, ovr_w;
   wire  [2:0] ready_w = {ready_c, ready_b, ready_a};

   uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
      .clk(clk), .rst(rst_ab), .rx(rx_a), .data_out(dout_a), .data_valid(valid[0]),
      .data_ready(ready_a), .parity_err(perr_w[0]), .frame_err(ferr_w[0]),
      .overrun(ovr_w[0]), .fifo_count(cnt_a));

   uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_b (
      .clk(clk), .rst(rst_ab), .rx(rx_b), .data_out(dout_b), .data_valid(valid[1]),
      .data_ready(ready_b), .parity_err(perr_w[1]), .frame_err(ferr_w[1]),
      .overrun(ovr_w[1]), .fifo_count(cnt_b));

   uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_c (
      .clk(clk), .rst(rst_c), .rx(rx_c), .data_out(dout_c), .data_valid(valid[2]),
      .data_ready(ready_c), .parity_err(perr_w[2]), .frame_err(ferr_w[2]),
      .overrun(ovr_w[2]), .fifo_count(cnt_c));

   int q0[$], q1[$], q2[$];
   int exp_perr[3], exp_ferr[3], exp_ovr[3];
   int got_perr[3], got_ferr[3], got_ovr[3];
   int total = 0;
   int bad   = 0;
   int mon_exp;
   bit rand_on = 1'b0;

   function automatic int db_of(input int k); return (k == 2) ? 7 : 8; endfunction
   function automatic int pm_of(input int k); return k;                endfunction
   function automatic int ns_of(input int k); return (k == 2) ? 2 : 1; endfunction

   function automatic int dout_of(input int k);
      case (k)
         0:       return int'(dout_a);
         1:       return int'(dout_b);
         default: return int'(dout_c);
      endcase
   endfunction

   function automatic int count_of(input int k);
      case (k)
         0:       return int'(cnt_a);
         1:       return int'(cnt_b);
         default: return int'(cnt_c);
      endcase
   endfunction

   function automatic int q_size(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic void q_push(input int k, input int v);
      case (k)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endfunction

   function automatic int q_pop(input int k);
      case (k)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic set_rx(input int k, input logic v);
      case (k)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   // Clock edges from the first driven edge to the edge that pushes or pulses.
   function automatic int push_at(input int nbits);
      return CPB * (nbits - 1) + CPB / 2 + 4;
   endfunction

   // Serialises one frame and, at the push edge, records what a correct receiver must do with it.
   task automatic send_frame(input int k, input int data, input bit flip, input bit bad_stop);
      int nb, p, s, pa, ones;
      int bits[$];
      bit pbit;
      nb = db_of(k);
      p  = pm_of(k);
      s  = ns_of(k);
      data = data & ((1 << nb) - 1);
      ones = $countones(data);
      bits.push_back(0);
      for (int i = 0; i < nb; i++) bits.push_back((data >> i) & 1);
      pbit = (p == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      if (p != 0) bits.push_back(int'(pbit ^ flip));
      for (int i = 0; i < s; i++) bits.push_back(bad_stop ? 0 : 1);
      pa = push_at(bits.size());
      @(posedge clk);
      #1;
      fork
         begin
            foreach (bits[i]) begin
               set_rx(k, bits[i] != 0);
               repeat (CPB) @(posedge clk);
               #1;
            end
         end
         begin
            repeat (pa) @(posedge clk);
            #2;
            if (bad_stop)                    exp_ferr[k]++;
            else if (p != 0 && flip)         exp_perr[k]++;
            else if (q_size(k) >= DEPTH)     exp_ovr[k]++;
            else                             q_push(k, data);
         end
      join
   endtask

   task automatic check_state(input int k, input string tag);
      check({tag, "_perr_pulses"}, got_perr[k], exp_perr[k]);
      check({tag, "_ferr_pulses"}, got_ferr[k], exp_ferr[k]);
      check({tag, "_ovr_pulses"},  got_ovr[k],  exp_ovr[k]);
      check({tag, "_fifo_count"},  count_of(k), q_size(k));
      check({tag, "_data_valid"},  int'(valid[k]), int'(q_size(k) != 0));
   endtask

   task automatic check_reset(input int k, input string tag);
      check({tag, "_count"},    count_of(k),     0);
      check({tag, "_valid"},    int'(valid[k]),  0);
      check({tag, "_data_out"}, dout_of(k),      0);
      check({tag, "_perr"},     int'(perr_w[k]), 0);
      check({tag, "_ferr"},     int'(ferr_w[k]), 0);
      check({tag, "_ovr"},      int'(ovr_w[k]),  0);
   endtask

   task automatic rand_frames(input int k);
      bit flip, brk;
      for (int i = 0; i < 12; i++) begin
         flip = ($urandom_range(0, 5) == 0);
         brk  = ($urandom_range(0, 7) == 0);
         send_frame(k, int'($urandom_range(0, 511)), flip, brk);
         if (brk) begin
            repeat (CPB) @(posedge clk);
            #1 set_rx(k, 1'b1);
            repeat (CPB) @(posedge clk);
            #1;
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

   // Monitor: counts pulses and checks every pop against the scoreboard.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (perr_w[k]) got_perr[k]++;
         if (ferr_w[k]) got_ferr[k]++;
         if (ovr_w[k])  got_ovr[k]++;
         if (ready_w[k]) begin
            if (q_size(k) > 0) begin
               mon_exp = q_pop(k);
               check("pop_valid", int'(valid[k]), 1);
               check("pop_data", dout_of(k), mon_exp);
            end else begin
               check("empty_valid", int'(valid[k]), 0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ab = 1'b0; rst_c = 1'b0;
      rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
      ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) check_reset(k, "reset");
      rst_ab = 1'b1; rst_c = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // 8N1 basic word, then a single-cycle pop.
      send_frame(0, 'hA5, 1'b0, 1'b0);
      repeat (CPB) @(posedge clk);
      #1;
      check("basic_data", int'(dout_a), 'hA5);
      check_state(0, "basic");
      ready_a = 1'b1;
      @(posedge clk);
      #1 ready_a = 1'b0;
      check("basic_pop_count", int'(cnt_a), 0);
      check("basic_pop_valid", int'(valid[0]), 0);

      // Bad stop bit followed by a held-low line, then a clean word.
      send_frame(0, 'h55, 1'b0, 1'b1);
      repeat (3 * CPB) @(posedge clk);
      #1;
      check_state(0, "break");
      rx_a = 1'b1;
      repeat (CPB) @(posedge clk);
      send_frame(0, 'h12, 1'b0, 1'b0);
      repeat (CPB) @(posedge clk);
      #1;
      check("after_break_data", int'(dout_a), 'h12);
      check_state(0, "after_break");
      ready_a = 1'b1;
      @(posedge clk);
      #1 ready_a = 1'b0;

      // Five back-to-back words into a four-deep FIFO.
      for (int v = 1; v <= 5; v++) send_frame(0, v, 1'b0, 1'b0);
      repeat (CPB) @(posedge clk);
      #1;
      check("overrun_count", int'(cnt_a), 4);
      check("overrun_pulses", got_ovr[0], 1);
      check_state(0, "overrun");

      // Full FIFO with a pop on the push edge: no overrun, new word goes last.
      fork
         send_frame(0, 'h06, 1'b0, 1'b0);
         begin
            @(posedge clk);
            repeat (push_at(10) - 1) @(posedge clk);
            #1 ready_a = 1'b1;
            @(posedge clk);
            #1 ready_a = 1'b0;
         end
      join
      repeat (CPB) @(posedge clk);
      #1;
      check("fullpop_count", int'(cnt_a), 4);
      check_state(0, "fullpop");
      ready_a = 1'b1;
      repeat (6) @(posedge clk);
      #1 ready_a = 1'b0;
      check_state(0, "drain_a");

      // Short low glitch must be rejected at the half-bit check.
      rx_a = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      #1 rx_a = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
      check_state(0, "glitch");

      // Even parity: correct then flipped parity bit.
      send_frame(1, 'h3C, 1'b0, 1'b0);
      repeat (CPB) @(posedge clk);
      #1;
      check("even_ok_data", int'(dout_b), 'h3C);
      check_state(1, "even_ok");
      send_frame(1, 'h3C, 1'b1, 1'b0);
      repeat (CPB) @(posedge clk);
      #1;
      check("even_bad_pulses", got_perr[1], 1);
      check_state(1, "even_bad");
      ready_b = 1'b1;
      @(posedge clk);
      #1 ready_b = 1'b0;

      // 7O2: one held word, reset in the middle of the next frame, then 0x5A.
      send_frame(2, 'h11, 1'b0, 1'b0);
      repeat (CPB) @(posedge clk);
      #1;
      check_state(2, "pre_reset");
      rx_c = 1'b0;
      repeat (3 * CPB) @(posedge clk);
      #1;
      rst_c = 1'b0;
      rx_c  = 1'b1;
      q2.delete();
      #1;
      check_reset(2, "midreset");
      repeat (3) @(posedge clk);
      #1 rst_c = 1'b1;
      repeat (4) @(posedge clk);
      send_frame(2, 'h5A, 1'b0, 1'b0);
      repeat (CPB) @(posedge clk);
      #1;
      check("post_reset_data", int'(dout_c), 'h5A);
      check_state(2, "post_reset");
      ready_c = 1'b1;
      @(posedge clk);
      #1 ready_c = 1'b0;

      // Randomised traffic on all three receivers with random consumers.
      rand_on = 1'b1;
      fork
         begin
            fork
               rand_frames(0);
               rand_frames(1);
               rand_frames(2);
            join
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk);
               #1;
               ready_a = ($urandom_range(0, 127) == 0);
               ready_b = ($urandom_range(0, 127) == 0);
               ready_c = ($urandom_range(0, 127) == 0);
            end
         end
      join
      ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
      repeat (2 * CPB) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) check_state(k, "random");
      ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
      for (int k = 0; k < 3; k++) check_state(k, "final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
